// File: rtl/mem_bank4_ctrl.sv
// Four-bank word-interleaved memory controller: one request per cycle, per-bank
// busy countdown, two-cycle registered read data and a registered illegal-request pulse.
module mem_bank4_ctrl #(
    parameter int BANK_DEPTH  = 1024,
    parameter int BANK_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] addr,
    input  logic [15:0] data_in,
    input  logic        wr,
    input  logic        rd,
    output logic [15:0] data_out,
    output logic        stall,
    output logic [3:0]  busy,
    output logic        err
);

    localparam int IDX_W = $clog2(BANK_DEPTH);
    localparam logic [2:0] CNT_LOAD = 3'(BANK_CYCLES);

    logic [1:0]       bankSel;
    logic [IDX_W-1:0] wordIdx;
    logic             illegalReq;
    logic             legalReq;
    logic             accept;
    logic             unusedAddr;

    logic [2:0]  cnt_q [4];
    logic [2:0]  cnt_d [4];
    logic [15:0] mem_q [4][BANK_DEPTH];
    logic [15:0] rdData_q;
    logic        rdValid_q;
    logic        rdValid_d;
    logic [15:0] dataOut_q;
    logic [15:0] dataOut_d;
    logic        err_q;

    assign bankSel    = addr[2:1];
    assign wordIdx    = addr[3 +: IDX_W];
    assign unusedAddr = ^(addr >> (3 + IDX_W));

    assign illegalReq = (rd & wr) | ((rd | wr) & addr[0]);
    assign legalReq   = (rd | wr) & ~illegalReq;
    assign stall      = legalReq & busy[bankSel];
    assign accept     = legalReq & ~busy[bankSel];

    always_comb begin
        for (int b = 0; b < 4; b++) begin
            busy[b] = (cnt_q[b] != 3'd0);
        end
    end

    // Only the addressed bank reloads; every other nonzero counter keeps draining.
    always_comb begin
        for (int b = 0; b < 4; b++) begin
            if (accept && (bankSel == 2'(b))) begin
                cnt_d[b] = CNT_LOAD;
            end else if (cnt_q[b] != 3'd0) begin
                cnt_d[b] = cnt_q[b] - 3'd1;
            end else begin
                cnt_d[b] = cnt_q[b];
            end
        end
    end

    assign rdValid_d = accept & rd;
    assign dataOut_d = rdValid_q ? rdData_q : 16'h0000;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int b = 0; b < 4; b++) begin
                cnt_q[b] <= 3'd0;
            end
            rdValid_q <= 1'b0;
            dataOut_q <= 16'h0000;
            err_q     <= 1'b0;
        end else begin
            for (int b = 0; b < 4; b++) begin
                cnt_q[b] <= cnt_d[b];
            end
            rdValid_q <= rdValid_d;
            dataOut_q <= dataOut_d;
            err_q     <= illegalReq;
        end
    end

    // Storage and the read sample are deliberately outside reset; a flushed read is
    // dropped through rdValid_q rather than by clearing the captured word.
    always_ff @(posedge clk) begin
        if (accept && wr) begin
            mem_q[bankSel][wordIdx] <= data_in;
        end
        if (accept && rd) begin
            rdData_q <= mem_q[bankSel][wordIdx];
        end
    end

    assign data_out = dataOut_q;
    assign err      = err_q;

endmodule

// File: tb/tb_mem_bank4_ctrl.sv
// Directed bench for mem_bank4_ctrl: a per-edge vector table plus a hand-written
// reset-during-read sequence, all expectations worked out by hand.
module tb_mem_bank4_ctrl;

    logic        clk;
    logic        rst;
    logic [15:0] addr;
    logic [15:0] data_in;
    logic        wr;
    logic        rd;
    logic [15:0] data_out;
    logic        stall;
    logic [3:0]  busy;
    logic        err;

    int testCount = 0;
    int failCount = 0;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [15:0] addr;
        logic [15:0] dataIn;
        logic        expStall;
        logic [3:0]  expBusy;
        logic [15:0] expData;
        logic        expErr;
    } vec_t;

    vec_t vecs[$];

    mem_bank4_ctrl #(
        .BANK_DEPTH  (1024),
        .BANK_CYCLES (4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .addr     (addr),
        .data_in  (data_in),
        .wr       (wr),
        .rd       (rd),
        .data_out (data_out),
        .stall    (stall),
        .busy     (busy),
        .err      (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic applyStimulus(input logic r, input logic w, input logic [15:0] a,
                                 input logic [15:0] d);
        rd      = r;
        wr      = w;
        addr    = a;
        data_in = d;
    endtask

    task automatic checkOutput(input string name, input logic [15:0] act,
                               input logic [15:0] exp);
        testCount++;
        if (act !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic addVec(input logic r, input logic w, input logic [15:0] a,
                          input logic [15:0] d, input logic s, input logic [3:0] b,
                          input logic [15:0] q, input logic e);
        vec_t v;
        v.rd = r; v.wr = w; v.addr = a; v.dataIn = d;
        v.expStall = s; v.expBusy = b; v.expData = q; v.expErr = e;
        vecs.push_back(v);
    endtask

    task automatic idle(input logic [3:0] b, input logic [15:0] q);
        addVec(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, b, q, 1'b0);
    endtask

    initial begin
        // Each row is one clock edge: stall is checked before the edge, the rest after it.
        // Write then read 0x0010 (bank 0, word 2).
        addVec(0, 1, 16'h0010, 16'hBEEF, 0, 4'b0001, 16'h0000, 0);
        idle(4'b0001, 16'h0000);
        idle(4'b0001, 16'h0000);
        idle(4'b0001, 16'h0000);
        idle(4'b0000, 16'h0000);
        addVec(1, 0, 16'h0010, 16'h0000, 0, 4'b0001, 16'h0000, 0);
        idle(4'b0001, 16'hBEEF);
        idle(4'b0001, 16'h0000);
        idle(4'b0001, 16'h0000);
        idle(4'b0000, 16'h0000);
        // Interleaved writes to all four banks.
        addVec(0, 1, 16'h0000, 16'h1111, 0, 4'b0001, 16'h0000, 0);
        addVec(0, 1, 16'h0002, 16'h2222, 0, 4'b0011, 16'h0000, 0);
        addVec(0, 1, 16'h0004, 16'h3333, 0, 4'b0111, 16'h0000, 0);
        addVec(0, 1, 16'h0006, 16'h4444, 0, 4'b1111, 16'h0000, 0);
        idle(4'b1110, 16'h0000);
        idle(4'b1100, 16'h0000);
        idle(4'b1000, 16'h0000);
        idle(4'b0000, 16'h0000);
        // Preload 0x0008 and 0x0018, both bank 0.
        addVec(0, 1, 16'h0008, 16'hA5A5, 0, 4'b0001, 16'h0000, 0);
        idle(4'b0001, 16'h0000);
        idle(4'b0001, 16'h0000);
        idle(4'b0001, 16'h0000);
        idle(4'b0000, 16'h0000);
        addVec(0, 1, 16'h0018, 16'h5A5A, 0, 4'b0001, 16'h0000, 0);
        idle(4'b0001, 16'h0000);
        idle(4'b0001, 16'h0000);
        idle(4'b0001, 16'h0000);
        idle(4'b0000, 16'h0000);
        // Bank conflict: the retry stalls for as long as busy[0] is high, including its last cycle.
        addVec(1, 0, 16'h0008, 16'h0000, 0, 4'b0001, 16'h0000, 0);
        addVec(1, 0, 16'h0018, 16'h0000, 1, 4'b0001, 16'hA5A5, 0);
        addVec(1, 0, 16'h0018, 16'h0000, 1, 4'b0001, 16'h0000, 0);
        addVec(1, 0, 16'h0018, 16'h0000, 1, 4'b0001, 16'h0000, 0);
        addVec(1, 0, 16'h0018, 16'h0000, 1, 4'b0000, 16'h0000, 0);
        addVec(1, 0, 16'h0018, 16'h0000, 0, 4'b0001, 16'h0000, 0);
        idle(4'b0001, 16'h5A5A);
        idle(4'b0001, 16'h0000);
        idle(4'b0001, 16'h0000);
        idle(4'b0000, 16'h0000);
        // Illegal requests, back to back, then confirm 0x0004 still holds 3333.
        addVec(1, 0, 16'h0003, 16'h0000, 0, 4'b0000, 16'h0000, 1);
        addVec(1, 1, 16'h0004, 16'hFFFF, 0, 4'b0000, 16'h0000, 1);
        idle(4'b0000, 16'h0000);
        addVec(1, 0, 16'h0004, 16'h0000, 0, 4'b0100, 16'h0000, 0);
        idle(4'b0100, 16'h3333);
        idle(4'b0100, 16'h0000);
        idle(4'b0100, 16'h0000);
        idle(4'b0000, 16'h0000);
        // An illegal request to a busy bank errors instead of stalling.
        addVec(0, 1, 16'h0002, 16'h7777, 0, 4'b0010, 16'h0000, 0);
        addVec(1, 0, 16'h0003, 16'h0000, 0, 4'b0010, 16'h0000, 1);
        idle(4'b0010, 16'h0000);
        idle(4'b0010, 16'h0000);
        idle(4'b0000, 16'h0000);
        // Word index wraps: 0x2000 aliases 0x0000.
        addVec(0, 1, 16'h2000, 16'h1234, 0, 4'b0001, 16'h0000, 0);
        idle(4'b0001, 16'h0000);
        idle(4'b0001, 16'h0000);
        idle(4'b0001, 16'h0000);
        idle(4'b0000, 16'h0000);
        addVec(1, 0, 16'h0000, 16'h0000, 0, 4'b0001, 16'h0000, 0);
        idle(4'b0001, 16'h1234);
        idle(4'b0001, 16'h0000);
        idle(4'b0001, 16'h0000);
        idle(4'b0000, 16'h0000);
        // Read bank 1 while writing bank 2; the read data must be unaffected.
        addVec(1, 0, 16'h0002, 16'h0000, 0, 4'b0010, 16'h0000, 0);
        addVec(0, 1, 16'h0014, 16'h9999, 0, 4'b0110, 16'h7777, 0);
        idle(4'b0110, 16'h0000);
        idle(4'b0110, 16'h0000);
        idle(4'b0100, 16'h0000);
        idle(4'b0000, 16'h0000);

        applyStimulus(1'b0, 1'b0, 16'h0000, 16'h0000);
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset data_out", data_out, 16'h0000);
        checkOutput("reset busy", {12'h000, busy}, 16'h0000);
        checkOutput("reset err", {15'h0000, err}, 16'h0000);
        checkOutput("reset stall", {15'h0000, stall}, 16'h0000);
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            applyStimulus(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].dataIn);
            #1;
            checkOutput($sformatf("step%0d stall", i), {15'h0000, stall},
                        {15'h0000, vecs[i].expStall});
            @(posedge clk);
            #1;
            checkOutput($sformatf("step%0d busy", i), {12'h000, busy},
                        {12'h000, vecs[i].expBusy});
            checkOutput($sformatf("step%0d data_out", i), data_out, vecs[i].expData);
            checkOutput($sformatf("step%0d err", i), {15'h0000, err},
                        {15'h0000, vecs[i].expErr});
        end

        // Reset lands the cycle after a read is accepted and must drop it.
        @(negedge clk);
        applyStimulus(1'b1, 1'b0, 16'h0010, 16'h0000);
        #1;
        checkOutput("rstmid accept stall", {15'h0000, stall}, 16'h0000);
        @(posedge clk);
        #1;
        checkOutput("rstmid busy before reset", {12'h000, busy}, 16'h0001);
        @(negedge clk);
        applyStimulus(1'b0, 1'b0, 16'h0000, 16'h0000);
        rst = 1'b0;
        #1;
        checkOutput("rstmid busy in reset", {12'h000, busy}, 16'h0000);
        checkOutput("rstmid data in reset", data_out, 16'h0000);
        checkOutput("rstmid err in reset", {15'h0000, err}, 16'h0000);
        @(posedge clk);
        #1;
        checkOutput("rstmid dropped read", data_out, 16'h0000);
        @(negedge clk);
        rst = 1'b1;
        applyStimulus(1'b1, 1'b0, 16'h0010, 16'h0000);
        #1;
        checkOutput("rstmid retry stall", {15'h0000, stall}, 16'h0000);
        @(posedge clk);
        #1;
        checkOutput("rstmid retry busy", {12'h000, busy}, 16'h0001);
        @(negedge clk);
        applyStimulus(1'b0, 1'b0, 16'h0000, 16'h0000);
        @(posedge clk);
        #1;
        checkOutput("rstmid retry data", data_out, 16'hBEEF);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
